// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: one 32-bit word per line,
// single outstanding miss serviced through the MemoryControl decoder port.
module icache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic        fetch_en,
    input  logic [31:0] fetch_addr,
    output logic        fetch_rdy,
    output logic [31:0] fetch_inst,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [31:0] mem_data
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 32 - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        RESP
    } state_e;

    state_e            state_q;
    logic              fetch_rdy_q;
    logic [31:0]       fetch_inst_q;
    logic              mem_en_q;
    logic [31:0]       mem_addr_q;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES];

    logic [INDEX_BITS-1:0] idx_f;
    logic [INDEX_BITS-1:0] idx_m;
    logic [TAG_W-1:0]      tag_f;
    logic [TAG_W-1:0]      tag_m;
    logic                  hit;
    logic                  fill;
    logic                  unused_ok;

    assign idx_f = fetch_addr[INDEX_BITS+1:2];
    assign tag_f = fetch_addr[31:INDEX_BITS+2];
    assign idx_m = mem_addr_q[INDEX_BITS+1:2];
    assign tag_m = mem_addr_q[31:INDEX_BITS+2];
    assign hit   = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    // A fill completes even when flush coincides with mem_rdy.
    assign fill  = rdy_in && (state_q == MISS) && mem_rdy;

    assign unused_ok = ^{fetch_addr[1:0], mem_addr_q[1:0]};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            fetch_rdy_q  <= 1'b0;
            fetch_inst_q <= '0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            valid_q      <= '0;
        end else if (rdy_in) begin
            if (fill) begin
                valid_q[idx_m] <= 1'b1;
            end
            if (flush) begin
                state_q     <= IDLE;
                fetch_rdy_q <= 1'b0;
                mem_en_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (fetch_en) begin
                            if (hit) begin
                                fetch_inst_q <= data_q[idx_f];
                                fetch_rdy_q  <= 1'b1;
                                state_q      <= RESP;
                            end else begin
                                mem_addr_q <= {fetch_addr[31:2], 2'b00};
                                mem_en_q   <= 1'b1;
                                state_q    <= MISS;
                            end
                        end
                    end
                    MISS: begin
                        if (mem_rdy) begin
                            fetch_inst_q <= mem_data;
                            fetch_rdy_q  <= 1'b1;
                            mem_en_q     <= 1'b0;
                            state_q      <= RESP;
                        end
                    end
                    RESP: begin
                        fetch_rdy_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                    default: begin
                        fetch_rdy_q <= 1'b0;
                        mem_en_q    <= 1'b0;
                        state_q     <= IDLE;
                    end
                endcase
            end
        end
    end

    // Tag and data arrays carry no reset; validity alone gates their use.
    always_ff @(posedge clk_in) begin
        if (fill) begin
            tag_q[idx_m]  <= tag_m;
            data_q[idx_m] <= mem_data;
        end
    end

    assign fetch_rdy  = fetch_rdy_q;
    assign fetch_inst = fetch_inst_q;
    assign mem_en     = mem_en_q;
    assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed plus randomized fetch sequences for icache, checked against a
// line-level model built from address arithmetic and a word-addressed memory.
module tb_icache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        fetch_en;
    logic [31:0] fetch_addr;
    logic        fetch_rdy;
    logic [31:0] fetch_inst;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic        mem_rdy;
    logic [31:0] mem_data;

    int n_cmp = 0;
    int n_err = 0;

    // Model: 16 lines, index = word address mod 16, tag = byte address / 64.
    bit              mv [16];
    int unsigned     mt [16];
    logic [31:0]     md [16];
    logic [31:0]     memimg [int unsigned];

    icache #(.INDEX_BITS(4)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .flush     (flush),
        .fetch_en  (fetch_en),
        .fetch_addr(fetch_addr),
        .fetch_rdy (fetch_rdy),
        .fetch_inst(fetch_inst),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdy   (mem_rdy),
        .mem_data  (mem_data)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (!memimg.exists(a)) memimg[a] = $urandom;
        return memimg[a];
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int unsigned idx = (a / 4) % 16;
        return mv[idx] && (mt[idx] == a / 64);
    endfunction

    function automatic void model_fill(input logic [31:0] a,
                                       input logic [31:0] d);
        int unsigned idx = (a / 4) % 16;
        mv[idx] = 1'b1;
        mt[idx] = a / 64;
        md[idx] = d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endtask

    // One complete request; a miss is answered lat cycles after mem_en rises.
    task automatic do_fetch(input logic [31:0] a, input int lat);
        int unsigned idx;
        logic [31:0] d;
        idx = (a / 4) % 16;
        d   = word_at(a);
        fetch_en   = 1'b1;
        fetch_addr = a;
        if (model_hit(a)) begin
            step();
            chk("hit_rdy", fetch_rdy, 1);
            chk("hit_inst", fetch_inst, md[idx]);
            chk("hit_mem_en", mem_en, 0);
        end else begin
            step();
            for (int i = 1; i <= lat; i++) begin
                chk("miss_mem_en", mem_en, 1);
                chk("miss_mem_addr", mem_addr, a);
                chk("miss_no_rdy", fetch_rdy, 0);
                if (i == lat) begin
                    mem_rdy  = 1'b1;
                    mem_data = d;
                end
                step();
            end
            mem_rdy  = 1'b0;
            mem_data = $urandom;
            chk("miss_rdy", fetch_rdy, 1);
            chk("miss_inst", fetch_inst, d);
            chk("miss_mem_en_fall", mem_en, 0);
            model_fill(a, d);
        end
        fetch_en   = 1'b0;
        fetch_addr = $urandom & 32'hFFFF_FFFC;
        step();
        chk("rdy_pulse_end", fetch_rdy, 0);
        chk("inst_hold", fetch_inst, d);
    endtask

    initial begin
        rst_in     = 1'b0;
        rdy_in     = 1'b1;
        flush      = 1'b0;
        fetch_en   = 1'b0;
        fetch_addr = '0;
        mem_rdy    = 1'b0;
        mem_data   = '0;
        model_reset();
        memimg[32'h104] = 32'h00A0_0093;

        #2;
        chk("rst_fetch_rdy", fetch_rdy, 0);
        chk("rst_fetch_inst", fetch_inst, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        step();
        step();
        rst_in = 1'b1;

        // Cold miss, then hit
        do_fetch(32'h104, 3);
        do_fetch(32'h104, 1);

        // fetch_en is ignored while the response is presented
        fetch_en   = 1'b1;
        fetch_addr = 32'h104;
        step();
        chk("resp_rdy", fetch_rdy, 1);
        chk("resp_inst", fetch_inst, 32'h00A0_0093);
        fetch_addr = 32'h7F0;
        step();
        chk("resp_ign_rdy", fetch_rdy, 0);
        chk("resp_ign_mem_en", mem_en, 0);
        fetch_en = 1'b0;
        step();
        chk("resp_ign_mem_en2", mem_en, 0);

        // Conflict on index 1
        do_fetch(32'h144, 2);
        do_fetch(32'h104, 1);

        // Flush during second miss cycle
        fetch_en   = 1'b1;
        fetch_addr = 32'h208;
        step();
        chk("fl_mem_en1", mem_en, 1);
        step();
        chk("fl_mem_en2", mem_en, 1);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        fetch_en = 1'b0;
        chk("fl_mem_en_off", mem_en, 0);
        chk("fl_no_rdy", fetch_rdy, 0);
        step();
        chk("fl_no_rdy2", fetch_rdy, 0);
        do_fetch(32'h208, 2);

        // Flush coincident with mem_rdy still fills the line
        fetch_en   = 1'b1;
        fetch_addr = 32'h30C;
        step();
        chk("flr_mem_en", mem_en, 1);
        mem_rdy  = 1'b1;
        mem_data = word_at(32'h30C);
        flush    = 1'b1;
        step();
        model_fill(32'h30C, word_at(32'h30C));
        mem_rdy  = 1'b0;
        flush    = 1'b0;
        fetch_en = 1'b0;
        chk("flr_no_rdy", fetch_rdy, 0);
        chk("flr_mem_en_off", mem_en, 0);
        step();
        chk("flr_no_rdy2", fetch_rdy, 0);
        do_fetch(32'h30C, 1);

        // Pause inside a miss
        fetch_en   = 1'b1;
        fetch_addr = 32'h410;
        step();
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("pause_mem_en", mem_en, 1);
            chk("pause_mem_addr", mem_addr, 32'h410);
            chk("pause_no_rdy", fetch_rdy, 0);
        end
        rdy_in   = 1'b1;
        mem_rdy  = 1'b1;
        mem_data = word_at(32'h410);
        step();
        mem_rdy = 1'b0;
        chk("pause_rdy", fetch_rdy, 1);
        chk("pause_inst", fetch_inst, word_at(32'h410));
        model_fill(32'h410, word_at(32'h410));
        fetch_en = 1'b0;
        step();
        chk("pause_rdy_end", fetch_rdy, 0);

        // Asynchronous reset mid-miss
        fetch_en   = 1'b1;
        fetch_addr = 32'h514;
        step();
        step();
        chk("rm_mem_en", mem_en, 1);
        rst_in = 1'b0;
        #2;
        chk("rm_mem_en_off", mem_en, 0);
        chk("rm_mem_addr", mem_addr, 0);
        chk("rm_fetch_rdy", fetch_rdy, 0);
        model_reset();
        fetch_en = 1'b0;
        #1;
        rst_in = 1'b1;
        step();
        do_fetch(32'h514, 2);
        do_fetch(32'h104, 1);

        // Randomized traffic over a small address pool to mix hits and misses
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 127)) * 4;
            if ($urandom_range(0, 3) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) step();
            end
            do_fetch(a, int'($urandom_range(1, 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
